// File: rtl/alu_arb.sv
// Two-port arbiter that shares one combinational ALU between two requesters,
// with a registered issue stage and a one-entry response buffer per port.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

module alu_arb #(
    parameter int unsigned FIX_PRIO = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     p0_req_valid,
    output logic                     p0_req_ready,
    input  logic [`ALU_OP_WIDTH-1:0] p0_req_op,
    input  logic [`CPU_WIDTH-1:0]    p0_req_src1,
    input  logic [`CPU_WIDTH-1:0]    p0_req_src2,
    output logic                     p0_rsp_valid,
    input  logic                     p0_rsp_ready,
    output logic [`CPU_WIDTH-1:0]    p0_rsp_res,
    output logic                     p0_rsp_zero,

    input  logic                     p1_req_valid,
    output logic                     p1_req_ready,
    input  logic [`ALU_OP_WIDTH-1:0] p1_req_op,
    input  logic [`CPU_WIDTH-1:0]    p1_req_src1,
    input  logic [`CPU_WIDTH-1:0]    p1_req_src2,
    output logic                     p1_rsp_valid,
    input  logic                     p1_rsp_ready,
    output logic [`CPU_WIDTH-1:0]    p1_rsp_res,
    output logic                     p1_rsp_zero,

    output logic [`ALU_OP_WIDTH-1:0] alu_op,
    output logic [`CPU_WIDTH-1:0]    alu_src1,
    output logic [`CPU_WIDTH-1:0]    alu_src2,
    input  logic [`CPU_WIDTH-1:0]    alu_res,
    input  logic                     alu_zero
);

    localparam int unsigned W  = `CPU_WIDTH;
    localparam int unsigned OW = `ALU_OP_WIDTH;

    logic [1:0]    req_valid, rsp_ready, rsp_hs, eligible, grant;
    logic          accept, acc_port;

    logic [1:0]    busy_q, busy_d;
    logic          last_gnt_q, last_gnt_d;
    logic          issue_vld_q, issue_vld_d;
    logic          issue_own_q, issue_own_d;
    logic [OW-1:0] issue_op_q, issue_op_d;
    logic [W-1:0]  issue_src1_q, issue_src1_d;
    logic [W-1:0]  issue_src2_q, issue_src2_d;
    logic [1:0]    rsp_vld_q, rsp_vld_d;
    logic [W-1:0]  rsp_res_q [2];
    logic [W-1:0]  rsp_res_d [2];
    logic [1:0]    rsp_zero_q, rsp_zero_d;

    assign req_valid = {p1_req_valid, p0_req_valid};
    assign rsp_ready = {p1_rsp_ready, p0_rsp_ready};
    assign rsp_hs    = rsp_vld_q & rsp_ready;

    // A response handshake frees its port in the same cycle.
    always_comb begin
        eligible = req_valid & (~busy_q | rsp_hs);
        grant    = 2'b00;
        if (eligible[0] && (FIX_PRIO != 0 || !eligible[1] || last_gnt_q)) begin
            grant[0] = 1'b1;
        end else if (eligible[1]) begin
            grant[1] = 1'b1;
        end
        accept   = |grant;
        acc_port = grant[1];
    end

    always_comb begin
        last_gnt_d   = accept ? acc_port : last_gnt_q;
        issue_vld_d  = accept;
        issue_own_d  = acc_port;
        issue_op_d   = '0;
        issue_src1_d = '0;
        issue_src2_d = '0;
        if (accept) begin
            issue_op_d   = acc_port ? p1_req_op   : p0_req_op;
            issue_src1_d = acc_port ? p1_req_src1 : p0_req_src1;
            issue_src2_d = acc_port ? p1_req_src2 : p0_req_src2;
        end

        for (int n = 0; n < 2; n++) begin
            busy_d[n]     = busy_q[n];
            rsp_vld_d[n]  = rsp_vld_q[n] & ~rsp_ready[n];
            rsp_res_d[n]  = rsp_res_q[n];
            rsp_zero_d[n] = rsp_zero_q[n];
            if (rsp_hs[n]) busy_d[n] = 1'b0;
            if (grant[n])  busy_d[n] = 1'b1;
            // Busy guarantees the owner's buffer is empty or draining here.
            if (issue_vld_q && int'(issue_own_q) == n) begin
                rsp_vld_d[n]  = 1'b1;
                rsp_res_d[n]  = alu_res;
                rsp_zero_d[n] = alu_zero;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= 2'b00;
            last_gnt_q   <= 1'b1;
            issue_vld_q  <= 1'b0;
            issue_own_q  <= 1'b0;
            issue_op_q   <= '0;
            issue_src1_q <= '0;
            issue_src2_q <= '0;
            rsp_vld_q    <= 2'b00;
            rsp_res_q    <= '{default: '0};
            rsp_zero_q   <= 2'b00;
        end else begin
            busy_q       <= busy_d;
            last_gnt_q   <= last_gnt_d;
            issue_vld_q  <= issue_vld_d;
            issue_own_q  <= issue_own_d;
            issue_op_q   <= issue_op_d;
            issue_src1_q <= issue_src1_d;
            issue_src2_q <= issue_src2_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_res_q    <= rsp_res_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign p0_req_ready = grant[0];
    assign p1_req_ready = grant[1];
    assign p0_rsp_valid = rsp_vld_q[0];
    assign p1_rsp_valid = rsp_vld_q[1];
    assign p0_rsp_res   = rsp_res_q[0];
    assign p1_rsp_res   = rsp_res_q[1];
    assign p0_rsp_zero  = rsp_zero_q[0];
    assign p1_rsp_zero  = rsp_zero_q[1];
    assign alu_op       = issue_op_q;
    assign alu_src1     = issue_src1_q;
    assign alu_src2     = issue_src2_q;

endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb: a round-robin and a fixed-priority instance share
// the same stimulus, each driving its own behavioural ALU.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

module tb_alu_arb;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRA = 4'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                     p0_req_valid = 1'b0, p1_req_valid = 1'b0;
    logic [`ALU_OP_WIDTH-1:0] p0_req_op = '0, p1_req_op = '0;
    logic [`CPU_WIDTH-1:0]    p0_req_src1 = '0, p0_req_src2 = '0;
    logic [`CPU_WIDTH-1:0]    p1_req_src1 = '0, p1_req_src2 = '0;
    logic                     p0_rsp_ready = 1'b1, p1_rsp_ready = 1'b1;

    logic                     rr_p0_req_ready, rr_p1_req_ready, rr_p0_rsp_valid, rr_p1_rsp_valid;
    logic [`CPU_WIDTH-1:0]    rr_p0_rsp_res, rr_p1_rsp_res;
    logic                     rr_p0_rsp_zero, rr_p1_rsp_zero;
    logic [`ALU_OP_WIDTH-1:0] rr_alu_op;
    logic [`CPU_WIDTH-1:0]    rr_alu_src1, rr_alu_src2, rr_alu_res;
    logic                     rr_alu_zero;

    logic                     fp_p0_req_ready, fp_p1_req_ready, fp_p0_rsp_valid, fp_p1_rsp_valid;
    logic [`CPU_WIDTH-1:0]    fp_p0_rsp_res, fp_p1_rsp_res;
    logic                     fp_p0_rsp_zero, fp_p1_rsp_zero;
    logic [`ALU_OP_WIDTH-1:0] fp_alu_op;
    logic [`CPU_WIDTH-1:0]    fp_alu_src1, fp_alu_src2, fp_alu_res;
    logic                     fp_alu_zero;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    assign rr_alu_res  = alu_f(rr_alu_op, rr_alu_src1, rr_alu_src2);
    assign rr_alu_zero = (rr_alu_res == '0);
    assign fp_alu_res  = alu_f(fp_alu_op, fp_alu_src1, fp_alu_src2);
    assign fp_alu_zero = (fp_alu_res == '0);

    alu_arb #(.FIX_PRIO(0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(rr_p0_req_ready), .p0_req_op(p0_req_op),
        .p0_req_src1(p0_req_src1), .p0_req_src2(p0_req_src2), .p0_rsp_valid(rr_p0_rsp_valid),
        .p0_rsp_ready(p0_rsp_ready), .p0_rsp_res(rr_p0_rsp_res), .p0_rsp_zero(rr_p0_rsp_zero),
        .p1_req_valid(p1_req_valid), .p1_req_ready(rr_p1_req_ready), .p1_req_op(p1_req_op),
        .p1_req_src1(p1_req_src1), .p1_req_src2(p1_req_src2), .p1_rsp_valid(rr_p1_rsp_valid),
        .p1_rsp_ready(p1_rsp_ready), .p1_rsp_res(rr_p1_rsp_res), .p1_rsp_zero(rr_p1_rsp_zero),
        .alu_op(rr_alu_op), .alu_src1(rr_alu_src1), .alu_src2(rr_alu_src2),
        .alu_res(rr_alu_res), .alu_zero(rr_alu_zero)
    );

    alu_arb #(.FIX_PRIO(1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(fp_p0_req_ready), .p0_req_op(p0_req_op),
        .p0_req_src1(p0_req_src1), .p0_req_src2(p0_req_src2), .p0_rsp_valid(fp_p0_rsp_valid),
        .p0_rsp_ready(p0_rsp_ready), .p0_rsp_res(fp_p0_rsp_res), .p0_rsp_zero(fp_p0_rsp_zero),
        .p1_req_valid(p1_req_valid), .p1_req_ready(fp_p1_req_ready), .p1_req_op(p1_req_op),
        .p1_req_src1(p1_req_src1), .p1_req_src2(p1_req_src2), .p1_rsp_valid(fp_p1_rsp_valid),
        .p1_rsp_ready(p1_rsp_ready), .p1_rsp_res(fp_p1_rsp_res), .p1_rsp_zero(fp_p1_rsp_zero),
        .alu_op(fp_alu_op), .alu_src1(fp_alu_src1), .alu_src2(fp_alu_src2),
        .alu_res(fp_alu_res), .alu_zero(fp_alu_zero)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drop_reqs();
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        p0_rsp_ready = 1'b1;
        p1_rsp_ready = 1'b1;
    endtask

    task automatic do_reset();
        drop_reqs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset values
        tick();
        settle();
        check_eq("rst p0_req_ready", rr_p0_req_ready, 0);
        check_eq("rst p1_req_ready", rr_p1_req_ready, 0);
        check_eq("rst p0_rsp_valid", rr_p0_rsp_valid, 0);
        check_eq("rst p1_rsp_valid", rr_p1_rsp_valid, 0);
        check_eq("rst p0_rsp_res", rr_p0_rsp_res, 0);
        check_eq("rst p1_rsp_zero", rr_p1_rsp_zero, 0);
        check_eq("rst alu_op", rr_alu_op, 0);
        check_eq("rst alu_src1", rr_alu_src1, 0);
        rst_n = 1'b1;

        // Single add, accepted in the first cycle after reset release
        p0_req_valid = 1'b1; p0_req_op = OP_ADD; p0_req_src1 = 5; p0_req_src2 = 7;
        settle();
        check_eq("add c0 p0_req_ready", rr_p0_req_ready, 1);
        check_eq("add c0 p1_req_ready", rr_p1_req_ready, 0);
        tick();
        p0_req_valid = 1'b0; p0_rsp_ready = 1'b0;
        settle();
        check_eq("add c1 alu_op", rr_alu_op, OP_ADD);
        check_eq("add c1 alu_src1", rr_alu_src1, 5);
        check_eq("add c1 alu_src2", rr_alu_src2, 7);
        check_eq("add c1 p0_rsp_valid", rr_p0_rsp_valid, 0);
        tick();
        settle();
        check_eq("add c2 p0_rsp_valid", rr_p0_rsp_valid, 1);
        check_eq("add c2 p0_rsp_res", rr_p0_rsp_res, 12);
        check_eq("add c2 p0_rsp_zero", rr_p0_rsp_zero, 0);
        p0_rsp_ready = 1'b1;
        tick();
        settle();
        check_eq("add c3 p0_rsp_valid", rr_p0_rsp_valid, 0);
        check_eq("add c3 res held", rr_p0_rsp_res, 12);
        check_eq("add c3 alu_op idle", rr_alu_op, 0);
        check_eq("add c3 alu_src1 idle", rr_alu_src1, 0);

        // Round-robin contention
        do_reset();
        p0_req_valid = 1'b1; p0_req_op = OP_SUB; p0_req_src1 = 3; p0_req_src2 = 3;
        p1_req_valid = 1'b1; p1_req_op = OP_OR;  p1_req_src1 = 1; p1_req_src2 = 2;
        for (int c = 0; c < 7; c++) begin
            settle();
            check_eq($sformatf("rr c%0d p0_req_ready", c), rr_p0_req_ready, (c % 2 == 0));
            check_eq($sformatf("rr c%0d p1_req_ready", c), rr_p1_req_ready, (c % 2 == 1));
            if (c >= 1)
                check_eq($sformatf("rr c%0d alu_op", c), rr_alu_op,
                         (c % 2 == 1) ? OP_SUB : OP_OR);
            if (c >= 2) begin
                check_eq($sformatf("rr c%0d p0_rsp_valid", c), rr_p0_rsp_valid, (c % 2 == 0));
                check_eq($sformatf("rr c%0d p1_rsp_valid", c), rr_p1_rsp_valid, (c % 2 == 1));
            end
            if (c == 4) begin
                check_eq("rr p0 res", rr_p0_rsp_res, 0);
                check_eq("rr p0 zero", rr_p0_rsp_zero, 1);
            end
            if (c == 5) begin
                check_eq("rr p1 res", rr_p1_rsp_res, 3);
                check_eq("rr p1 zero", rr_p1_rsp_zero, 0);
            end
            tick();
        end

        // Fixed priority versus round-robin on a tie after a port 0 grant
        do_reset();
        p0_req_valid = 1'b1; p0_req_op = OP_ADD; p0_req_src1 = 1; p0_req_src2 = 1;
        settle();
        check_eq("fp c0 rr p0_req_ready", rr_p0_req_ready, 1);
        check_eq("fp c0 fp p0_req_ready", fp_p0_req_ready, 1);
        tick();
        settle();
        check_eq("fp c1 rr p0_req_ready", rr_p0_req_ready, 0);
        check_eq("fp c1 fp p0_req_ready", fp_p0_req_ready, 0);
        tick();
        p1_req_valid = 1'b1; p1_req_op = OP_OR; p1_req_src1 = 1; p1_req_src2 = 2;
        settle();
        check_eq("fp c2 rr p0_req_ready", rr_p0_req_ready, 0);
        check_eq("fp c2 rr p1_req_ready", rr_p1_req_ready, 1);
        check_eq("fp c2 fp p0_req_ready", fp_p0_req_ready, 1);
        check_eq("fp c2 fp p1_req_ready", fp_p1_req_ready, 0);
        tick();
        settle();
        check_eq("fp c3 rr p0_req_ready", rr_p0_req_ready, 1);
        check_eq("fp c3 rr p1_req_ready", rr_p1_req_ready, 0);
        check_eq("fp c3 fp p0_req_ready", fp_p0_req_ready, 0);
        check_eq("fp c3 fp p1_req_ready", fp_p1_req_ready, 1);
        tick();

        // Response backpressure on port 1
        do_reset();
        p0_req_valid = 1'b1; p0_req_op = OP_ADD; p0_req_src1 = 2; p0_req_src2 = 3;
        p1_req_valid = 1'b1; p1_req_op = OP_OR;  p1_req_src1 = 1; p1_req_src2 = 2;
        p1_rsp_ready = 1'b0;
        settle();
        check_eq("bp c0 p0_req_ready", rr_p0_req_ready, 1);
        tick();
        settle();
        check_eq("bp c1 p1_req_ready", rr_p1_req_ready, 1);
        tick();
        p1_req_op = OP_XOR; p1_req_src1 = 6; p1_req_src2 = 3;
        settle();
        check_eq("bp c2 p0_req_ready", rr_p0_req_ready, 1);
        tick();
        for (int c = 3; c < 13; c++) begin
            settle();
            check_eq($sformatf("bp c%0d p1_rsp_valid", c), rr_p1_rsp_valid, 1);
            check_eq($sformatf("bp c%0d p1_rsp_res", c), rr_p1_rsp_res, 3);
            check_eq($sformatf("bp c%0d p1_req_ready", c), rr_p1_req_ready, 0);
            check_eq($sformatf("bp c%0d p0_req_ready", c), rr_p0_req_ready, (c % 2 == 0));
            tick();
        end
        p1_rsp_ready = 1'b1;
        settle();
        check_eq("bp c13 p1_req_ready", rr_p1_req_ready, 1);
        check_eq("bp c13 p0_req_ready", rr_p0_req_ready, 0);
        tick();
        p1_req_valid = 1'b0;
        settle();
        check_eq("bp c14 p1_rsp_valid", rr_p1_rsp_valid, 0);
        tick();
        settle();
        check_eq("bp c15 p1_rsp_valid", rr_p1_rsp_valid, 1);
        check_eq("bp c15 p1_rsp_res", rr_p1_rsp_res, 5);
        tick();

        // Back-to-back on the same port
        do_reset();
        p0_req_valid = 1'b1; p0_req_op = OP_SLL; p0_req_src1 = 1; p0_req_src2 = 4;
        settle();
        check_eq("b2b c0 p0_req_ready", rr_p0_req_ready, 1);
        tick();
        p0_req_op = OP_SRA; p0_req_src1 = 32'h8000_0000; p0_req_src2 = 4;
        settle();
        check_eq("b2b c1 p0_req_ready", rr_p0_req_ready, 0);
        tick();
        settle();
        check_eq("b2b c2 p0_req_ready", rr_p0_req_ready, 1);
        check_eq("b2b c2 p0_rsp_valid", rr_p0_rsp_valid, 1);
        check_eq("b2b c2 p0_rsp_res", rr_p0_rsp_res, 16);
        tick();
        p0_req_valid = 1'b0;
        settle();
        check_eq("b2b c3 p0_rsp_valid", rr_p0_rsp_valid, 0);
        check_eq("b2b c3 alu_op", rr_alu_op, OP_SRA);
        tick();
        settle();
        check_eq("b2b c4 p0_rsp_valid", rr_p0_rsp_valid, 1);
        check_eq("b2b c4 p0_rsp_res", rr_p0_rsp_res, 32'hF800_0000);
        check_eq("b2b c4 p0_rsp_zero", rr_p0_rsp_zero, 0);
        tick();

        // Reset in the cycle after an accept
        do_reset();
        p0_req_valid = 1'b1; p0_req_op = OP_ADD; p0_req_src1 = 5; p0_req_src2 = 7;
        settle();
        check_eq("mid c0 p0_req_ready", rr_p0_req_ready, 1);
        tick();
        p0_req_valid = 1'b0;
        rst_n = 1'b0;
        settle();
        check_eq("mid alu_op", rr_alu_op, 0);
        check_eq("mid alu_src1", rr_alu_src1, 0);
        check_eq("mid p0_req_ready", rr_p0_req_ready, 0);
        tick();
        settle();
        check_eq("mid p0_rsp_valid", rr_p0_rsp_valid, 0);
        check_eq("mid p0_rsp_res", rr_p0_rsp_res, 0);
        rst_n = 1'b1;
        p0_req_valid = 1'b1; p0_req_op = OP_SUB; p0_req_src1 = 9; p0_req_src2 = 4;
        settle();
        check_eq("mid rel p0_req_ready", rr_p0_req_ready, 1);
        check_eq("mid rel p0_rsp_valid", rr_p0_rsp_valid, 0);
        tick();
        p0_req_valid = 1'b0;
        settle();
        check_eq("mid rel+1 p0_rsp_valid", rr_p0_rsp_valid, 0);
        tick();
        settle();
        check_eq("mid rel+2 p0_rsp_valid", rr_p0_rsp_valid, 1);
        check_eq("mid rel+2 p0_rsp_res", rr_p0_rsp_res, 5);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
